// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types and constants for the SPI frame master.
//   state_t  : frame sequencer states
//   SPI_WIDTH: frame length in bits, matched to the slave's frame
//   SCK_IDLE : level of sck between frames
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int   SPI_WIDTH = 32;
  localparam logic SCK_IDLE  = 1'b1;

endpackage

// File: rtl/spi_frame_master_bit_sync.sv
// bit_sync: two-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk   in  destination clock
//   reset in  asynchronous, active-high; clears both flops to 0
//   d     in  asynchronous input
//   q     out synchronised output
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI master that sends one WIDTH-bit frame MSB first on
// sdo and captures a WIDTH-bit reply from sdi per accepted start. The slave
// samples sdo and shifts sdi on falling sck; this side samples sdi (through
// a 2-FF synchroniser) at the end of each sck-low phase.
// Ports:
//   vgaclk   in  system clock
//   reset    in  asynchronous, active-high
//   start    in  frame request, only looked at in IDLE
//   tx_data  in  word to send, latched on acceptance
//   busy     out frame in progress
//   done     out one-cycle pulse at frame end
//   rx_data  out last received word, updated at done
//   rx_valid out set at first done, cleared only by reset
//   sck      out SPI clock, idles high
//   sdo      out master-out data
//   sdi      in  master-in data, asynchronous
//   cs_n     out active-low frame enable
//
// state | meaning
// IDLE  | waiting for start, cs_n high
// SETUP | cs_n low, first bit on sdo, sck still high
// LOW   | sck low, slave has sampled current bit
// HIGH  | sck high, next bit on sdo
// HOLD  | last bit captured, cs_n held low before release
import spi_master_pkg::*;

module spi_frame_master #(
  parameter int CLKDIV = 4,
  parameter int WIDTH  = SPI_WIDTH
) (
  input  logic             vgaclk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             sck,
  output logic             sdo,
  input  logic             sdi,
  output logic             cs_n
);

  localparam int              BW       = $clog2(WIDTH);
  localparam logic [7:0]      DIV_LAST = 8'(CLKDIV - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

  state_t           state;
  logic [7:0]       divcnt;
  logic [BW-1:0]    bitcnt;
  // The MSB goes straight to sdo at acceptance, so only the remaining
  // WIDTH-1 bits need to be held for shifting.
  logic [WIDTH-2:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             sdi_sync;
  logic             tick;

  bit_sync u_sdi_sync (
    .clk   (vgaclk),
    .reset (reset),
    .d     (sdi),
    .q     (sdi_sync)
  );

  assign tick = (divcnt == DIV_LAST);

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      divcnt   <= '0;
      bitcnt   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      sck      <= SCK_IDLE;
      sdo      <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      done <= 1'b0;

      if (state == IDLE || tick) divcnt <= '0;
      else                       divcnt <= divcnt + 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            tx_sr  <= tx_data[WIDTH-2:0];
            sdo    <= tx_data[WIDTH-1];
            cs_n   <= 1'b0;
            bitcnt <= '0;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sck   <= 1'b0;
            state <= LOW;
          end
        end
        LOW: begin
          if (tick) begin
            sck   <= 1'b1;
            rx_sr <= {rx_sr[WIDTH-2:0], sdi_sync};
            if (bitcnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              sdo    <= tx_sr[WIDTH-2];
              tx_sr  <= {tx_sr[WIDTH-3:0], 1'b0};
              state  <= HIGH;
            end
          end
        end
        HIGH: begin
          if (tick) begin
            sck   <= 1'b0;
            state <= LOW;
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n     <= 1'b1;
            sdo      <= 1'b0;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: scoreboard bench for spi_frame_master with a
// behavioural SPI slave (samples sdo, shifts reply out on falling sck).
module tb_spi_frame_master;

  localparam int CLKDIV = 4;
  localparam int WIDTH  = 32;
  localparam int LAT    = (2 * WIDTH + 1) * CLKDIV;

  logic             vgaclk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             busy, done, rx_valid, sck, sdo, cs_n;
  logic [WIDTH-1:0] rx_data;
  logic             sdi;

  spi_frame_master #(.CLKDIV(CLKDIV), .WIDTH(WIDTH)) dut (
    .vgaclk   (vgaclk),
    .reset    (reset),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .sck      (sck),
    .sdo      (sdo),
    .sdi      (sdi),
    .cs_n     (cs_n)
  );

  always #20 vgaclk = ~vgaclk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge vgaclk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] reply;
    int               done_cyc;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] reply_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural slave: takes its reply word at cs_n fall and puts reply bit
  // k on sdi at falling edge k, while shifting sdo into its capture word.
  logic [WIDTH-1:0] s_reply, s_cap;
  int               s_idx, s_falls;

  always @(negedge cs_n) begin
    s_reply = (reply_q.size() > 0) ? reply_q.pop_front() : '0;
    s_idx   = 0;
    s_falls = 0;
    s_cap   = '0;
  end

  always @(negedge sck) begin
    if (cs_n === 1'b0) begin
      s_cap = {s_cap[WIDTH-2:0], sdo};
      s_falls++;
      sdi = (s_idx < WIDTH) ? s_reply[WIDTH-1-s_idx] : 1'b0;
      s_idx++;
    end
  end

  // Monitor: every done pulse is matched against the oldest expected frame.
  logic prev_done = 1'b0;
  always @(negedge vgaclk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      check("done_width", {63'd0, prev_done}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", {32'd0, rx_data}, {32'd0, e.reply});
        check("slave_cap", {32'd0, s_cap}, {32'd0, e.tx});
        check("done_latency", 64'(cyc), 64'(e.done_cyc));
        check("sck_falls", 64'(s_falls), 64'(WIDTH));
        check("rx_valid", {63'd0, rx_valid}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("cs_n_at_done", {63'd0, cs_n}, 64'd1);
      end
    end
    prev_done = (reset === 1'b0) ? done : 1'b0;
  end

  // Drives one start pulse and records what the frame must produce.
  task automatic issue(input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] rep, output int acc);
    @(negedge vgaclk);
    tx_data = tx;
    start   = 1'b1;
    acc     = cyc + 1;
    reply_q.push_back(rep);
    sb.push_back('{tx, rep, acc + LAT});
    @(negedge vgaclk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge vgaclk);
  endtask

  initial begin
    int acc;
    logic [WIDTH-1:0] r;

    reset   = 1'b1;
    start   = 1'b0;
    tx_data = '0;
    sdi     = 1'b0;
    repeat (3) @(negedge vgaclk);
    reset = 1'b0;

    // Quiet bus after reset.
    for (int i = 0; i < 100; i++) begin
      @(negedge vgaclk);
      check("idle_outputs", {58'd0, sck, cs_n, sdo, busy, done, rx_valid}, 64'b110000);
    end
    check("idle_rx_data", {32'd0, rx_data}, 64'd0);

    // Basic frame.
    issue(32'hA5C3_0F81, 32'h1234_5678, acc);
    wait_until(acc + LAT + 10);

    // start held high: two back-to-back frames, cs_n high for one cycle.
    @(negedge vgaclk);
    tx_data = 32'hFFFF_0000;
    start   = 1'b1;
    acc     = cyc + 1;
    reply_q.push_back(32'h0F0F_F0F0);
    reply_q.push_back(32'h8000_0001);
    sb.push_back('{32'hFFFF_0000, 32'h0F0F_F0F0, acc + LAT});
    sb.push_back('{32'hFFFF_0000, 32'h8000_0001, acc + 2 * LAT + 1});
    wait_until(acc + LAT);
    check("gap_cs_n_high", {63'd0, cs_n}, 64'd1);
    @(negedge vgaclk);
    check("gap_cs_n_low", {63'd0, cs_n}, 64'd0);
    wait_until(acc + 299);
    start = 1'b0;
    wait_until(acc + 2 * LAT + 1 + 10);

    // starts during a frame are ignored.
    issue(32'h1357_9BDF, 32'hCAFE_F00D, acc);
    for (int k = 0; k < 3; k++) begin
      int off;
      off = (k == 0) ? 10 : (k == 1) ? 50 : 200;
      wait_until(acc + off - 1);
      tx_data = $urandom;
      start   = 1'b1;
      @(negedge vgaclk);
      start = 1'b0;
    end
    wait_until(acc + LAT + 10);

    // tx_data changes after acceptance have no effect.
    issue(32'hDEAD_BEEF, 32'h5555_AAAA, acc);
    wait_until(acc + 20);
    tx_data = '0;
    wait_until(acc + LAT + 10);

    // Reset mid-frame.
    issue(32'h0123_4567, 32'h89AB_CDEF, acc);
    wait_until(acc + 129);
    reset = 1'b1;
    #1;
    sb.delete();
    reply_q.delete();
    check("rst_outputs", {58'd0, sck, cs_n, sdo, busy, done, rx_valid}, 64'b110000);
    check("rst_rx_data", {32'd0, rx_data}, 64'd0);
    repeat (3) @(negedge vgaclk);
    reset = 1'b0;
    repeat (5) @(negedge vgaclk);
    issue(32'hC001_D00D, 32'h7E57_0BAD, acc);
    wait_until(acc + LAT + 10);

    // Randomised frames with random idle gaps.
    for (int n = 0; n < 8; n++) begin
      r = $urandom;
      issue($urandom, r, acc);
      wait_until(acc + LAT + 1 + int'($urandom_range(0, 20)));
    end

    repeat (20) @(negedge vgaclk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
